// File: rtl/fsm_ctx_scheduler_if.sv
// Purpose: request/result bundle between serial bit sources, the context scheduler and result consumers.
// Latency: none; this file only declares signals.
// Backpressure: req_ready is the per-channel grant, and a bit is consumed on req_valid & req_ready.
interface fsm_ctx_scheduler_if #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
);
    logic [N_CH-1:0] req_valid;
    logic [N_CH-1:0] req_bit;
    logic [N_CH-1:0] req_ready;
    logic [N_CH-1:0] clr;
    logic            res_valid;
    logic [CH_W-1:0] res_ch;
    logic            res_bit;
    logic [3:0]      res_state;

    // Bit sources and result consumers
    modport master (
        output req_valid, req_bit, clr,
        input  req_ready, res_valid, res_ch, res_bit, res_state
    );

    // Scheduler
    modport slave (
        input  req_valid, req_bit, clr,
        output req_ready, res_valid, res_ch, res_bit, res_state
    );
endinterface

// File: rtl/fsm_ctx_scheduler.sv
// Purpose: one 4-state Mealy sequence engine shared round-robin across N_CH streams with per-channel saved contexts.
// Latency: a result is registered 1 cycle after its grant, and the scheduler can take one bit per cycle in aggregate.
// Backpressure: req_ready is a combinational one-hot grant. A requester that is not granted holds its bit, and clr blocks the grant.
module fsm_ctx_scheduler #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                reset,
    fsm_ctx_scheduler_if.slave  bus
);

    typedef enum logic [3:0] {
        S0 = 4'b0001,
        S1 = 4'b0010,
        S2 = 4'b0100,
        S3 = 4'b1000
    } state_t;

    logic [3:0]      ctx [N_CH];
    logic [CH_W-1:0] rr_ptr;

    logic [N_CH-1:0] elig;
    logic            grant;
    logic [CH_W-1:0] gnt_idx;
    logic [N_CH-1:0] ready;

    logic [3:0]      cur_state;
    logic            cur_bit;
    logic [3:0]      nxt_state;
    logic            nxt_out;

    logic            res_valid_q;
    logic [CH_W-1:0] res_ch_q;
    logic            res_bit_q;
    logic [3:0]      res_state_q;

    // Round-robin search that starts just after the last granted channel. A cleared channel is never eligible.
    always_comb begin
        int unsigned idx;
        elig    = bus.req_valid & ~bus.clr;
        grant   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!grant && elig[idx]) begin
                grant   = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
    end

    // Drive the one-hot grant to the winner. The grant is held off while reset is asserted.
    always_comb begin
        ready = '0;
        if (grant && !reset) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = ready;

    // Mealy next-state/output for the granted channel's saved context. A corrupt (non-one-hot) context recovers to S0.
    always_comb begin
        cur_state = ctx[gnt_idx];
        cur_bit   = bus.req_bit[gnt_idx];
        nxt_state = S0;
        nxt_out   = 1'b0;
        case (cur_state)
            S0: begin
                nxt_state = cur_bit ? S1 : S0;
                nxt_out   = cur_bit;
            end
            S1: begin
                nxt_state = cur_bit ? S3 : S2;
                nxt_out   = ~cur_bit;
            end
            S2: begin
                nxt_state = cur_bit ? S3 : S0;
                nxt_out   = cur_bit;
            end
            S3: begin
                nxt_state = cur_bit ? S0 : S3;
                nxt_out   = cur_bit;
            end
            default: begin
                nxt_state = S0;
                nxt_out   = 1'b0;
            end
        endcase
    end

    // Context bank: clr wins over everything. Only the granted channel advances, and all other channels hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                ctx[i] <= S0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.clr[i]) begin
                    ctx[i] <= S0;
                end else if (grant && (gnt_idx == CH_W'(i))) begin
                    ctx[i] <= nxt_state;
                end
            end
        end
    end

    // Registered result and arbitration pointer. Both update only on a grant, except valid, which follows the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= CH_W'(N_CH - 1);
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_bit_q   <= 1'b0;
            res_state_q <= S0;
        end else begin
            res_valid_q <= grant;
            if (grant) begin
                rr_ptr      <= gnt_idx;
                res_ch_q    <= gnt_idx;
                res_bit_q   <= nxt_out;
                res_state_q <= nxt_state;
            end
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_bit   = res_bit_q;
    assign bus.res_state = res_state_q;

endmodule
